// File: rtl/lsu_if.sv
// Core-side request/response and data-memory bus interfaces for the load/store unit.
// master = initiator of the request on each link.
interface lsu_req_if;
    logic        req_valid;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_wen, req_addr, req_wdata, req_size, req_unsigned,
        input  resp_valid, resp_rdata, resp_err
    );
    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, req_size, req_unsigned,
        output resp_valid, resp_rdata, resp_err
    );
endinterface

interface lsu_mem_if;
    logic        mem_reqValid;
    logic        mem_reqReady;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_respValid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_reqValid, mem_wen, mem_addr, mem_wdata, mem_wstrb,
        input  mem_reqReady, mem_respValid, mem_rdata
    );
    modport slave (
        input  mem_reqValid, mem_wen, mem_addr, mem_wdata, mem_wstrb,
        output mem_reqReady, mem_respValid, mem_rdata
    );
endinterface

// File: rtl/lsu.sv
// Load/store unit: one core request -> one word-aligned bus transaction, formatted response.
// Optional misalignment trap enabled by defining LSU_MISALIGN_TRAP_EN.
module lsu (
    input  logic            clock,
    input  logic            reset,
    lsu_req_if.slave        core,
    lsu_mem_if.master       mem
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

    state_t      r_state;
    logic        r_wen;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [1:0]  r_lo;
    logic        r_mem_req_valid;
    logic        r_mem_wen;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [3:0]  r_mem_wstrb;
    logic        r_resp_valid;
    logic [31:0] r_resp_rdata;
    logic        r_resp_err;

    logic        w_trap;
    logic [1:0]  w_addr_lo;
    logic [31:0] w_wdata;
    logic [3:0]  w_wstrb;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_trap = ((core.req_size == 2'b01) && core.req_addr[0]) ||
                    (core.req_size[1] && (core.req_addr[1:0] != 2'b00));
`else
    assign w_trap = 1'b0;
`endif

    // Natural alignment of the low address bits; misaligned requests either trap or get forced aligned.
    always_comb begin
        w_addr_lo = core.req_addr[1:0];
        w_wdata   = core.req_wdata;
        w_wstrb   = 4'b1111;
        case (core.req_size)
            2'b00: begin
                w_wdata = {4{core.req_wdata[7:0]}};
                w_wstrb = 4'b0001 << core.req_addr[1:0];
            end
            2'b01: begin
                w_addr_lo = {core.req_addr[1], 1'b0};
                w_wdata   = {2{core.req_wdata[15:0]}};
                w_wstrb   = core.req_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: w_addr_lo = 2'b00;
        endcase
        if (!core.req_wen) w_wstrb = 4'b0000;
    end

    // Lane select and extension of the returned read word.
    always_comb begin
        case (r_lo)
            2'd0:    w_byte = mem.mem_rdata[7:0];
            2'd1:    w_byte = mem.mem_rdata[15:8];
            2'd2:    w_byte = mem.mem_rdata[23:16];
            default: w_byte = mem.mem_rdata[31:24];
        endcase
        w_half = r_lo[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
        case (r_size)
            2'b00:   w_load = {{24{~r_unsigned & w_byte[7]}}, w_byte};
            2'b01:   w_load = {{16{~r_unsigned & w_half[15]}}, w_half};
            default: w_load = mem.mem_rdata;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_wen           <= 1'b0;
            r_size          <= 2'b00;
            r_unsigned      <= 1'b0;
            r_lo            <= 2'b00;
            r_mem_req_valid <= 1'b0;
            r_mem_wen       <= 1'b0;
            r_mem_addr      <= 32'h0;
            r_mem_wdata     <= 32'h0;
            r_mem_wstrb     <= 4'b0000;
            r_resp_valid    <= 1'b0;
            r_resp_rdata    <= 32'h0;
            r_resp_err      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (core.req_valid) begin
                        r_wen      <= core.req_wen;
                        r_size     <= core.req_size;
                        r_unsigned <= core.req_unsigned;
                        r_lo       <= w_addr_lo;
                        if (w_trap) begin
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= 32'h0;
                            r_state      <= S_RESP;
                        end else begin
                            r_mem_req_valid <= 1'b1;
                            r_mem_wen       <= core.req_wen;
                            r_mem_addr      <= {core.req_addr[31:2], 2'b00};
                            r_mem_wdata     <= w_wdata;
                            r_mem_wstrb     <= w_wstrb;
                            r_state         <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (mem.mem_reqReady) begin
                        r_mem_req_valid <= 1'b0;
                        r_state         <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem.mem_respValid) begin
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b0;
                        r_resp_rdata <= r_wen ? 32'h0 : w_load;
                        r_state      <= S_RESP;
                    end
                end
                default: begin
                    r_resp_valid <= 1'b0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    assign core.resp_valid  = r_resp_valid;
    assign core.resp_rdata  = r_resp_rdata;
    assign core.resp_err    = r_resp_err;
    assign mem.mem_reqValid = r_mem_req_valid;
    assign mem.mem_wen      = r_mem_wen;
    assign mem.mem_addr     = r_mem_addr;
    assign mem.mem_wdata    = r_mem_wdata;
    assign mem.mem_wstrb    = r_mem_wstrb;
endmodule
